// File: rtl/sdc_single_blk_wr_mod.sv
// SD card single-block write datapath: serialises one BRAM block onto D0,
// appends CRC16, then collects the card's CRC status token and waits out busy.
module sdc_single_blk_wr_mod #(
    parameter int NWR_CYC      = 2,
    parameter int WORDS        = 64,
    parameter int STAT_TIMEOUT = 64
) (
    input  logic        sdc_clk,
    input  logic        reset,
    input  logic [15:0] command,
    input  logic        strt_strb,
    input  logic [63:0] dat_wrd,
    input  logic        d0_in,
    output logic        rd_wrd_strb,
    output logic        d0_out,
    output logic        d0_oe,
    output logic        busy,
    output logic        crc_stat_err,
    output logic        tfc,
    output logic [15:0] crc_16
);

    localparam int CW = 16;
    localparam int WW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int NS = 10;

    localparam int I_IDLE  = 0;
    localparam int I_PRE   = 1;
    localparam int I_STRT  = 2;
    localparam int I_DATA  = 3;
    localparam int I_CRC   = 4;
    localparam int I_END   = 5;
    localparam int I_WSTAT = 6;
    localparam int I_STAT  = 7;
    localparam int I_BUSYW = 8;
    localparam int I_DONE  = 9;

    localparam logic [NS-1:0] ST_IDLE  = NS'(1) << I_IDLE;
    localparam logic [NS-1:0] ST_PRE   = NS'(1) << I_PRE;
    localparam logic [NS-1:0] ST_STRT  = NS'(1) << I_STRT;
    localparam logic [NS-1:0] ST_DATA  = NS'(1) << I_DATA;
    localparam logic [NS-1:0] ST_CRC   = NS'(1) << I_CRC;
    localparam logic [NS-1:0] ST_END   = NS'(1) << I_END;
    localparam logic [NS-1:0] ST_WSTAT = NS'(1) << I_WSTAT;
    localparam logic [NS-1:0] ST_STAT  = NS'(1) << I_STAT;
    localparam logic [NS-1:0] ST_BUSYW = NS'(1) << I_BUSYW;
    localparam logic [NS-1:0] ST_DONE  = NS'(1) << I_DONE;

    logic [NS-1:0] state;
    logic [NS-1:0] state_nx;
    logic [CW-1:0] cnt;
    logic [WW-1:0] wcnt;
    logic [63:0]   shift;
    logic [63:0]   hold;
    logic          rd_q;
    logic [15:0]   crc;
    logic [15:0]   crc_step;
    logic [1:0]    tok;
    logic          is_wr;
    logic          accept;
    logic          last_bit;
    logic          last_word;
    logic          unused_cmd;

    assign unused_cmd = ^{command[15:14], command[7:0]};
    assign is_wr      = (command[13:8] == 6'h18) || (command[13:8] == 6'h19);
    assign accept     = state[I_IDLE] && strt_strb && is_wr;
    assign last_bit   = (cnt == CW'(63));
    assign last_word  = (wcnt == WW'(WORDS - 1));
    assign crc_step   = {crc[14:0], 1'b0}
                      ^ ((crc[15] ^ shift[63]) ? 16'h1021 : 16'h0000);

    always_ff @(posedge sdc_clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = ST_IDLE;
        unique case (1'b1)
            state[I_IDLE]:
                state_nx = accept ? ST_PRE : ST_IDLE;
            state[I_PRE]:
                state_nx = (cnt == CW'(NWR_CYC - 1)) ? ST_STRT : ST_PRE;
            state[I_STRT]:
                state_nx = ST_DATA;
            state[I_DATA]:
                state_nx = (last_bit && last_word) ? ST_CRC : ST_DATA;
            state[I_CRC]:
                state_nx = (cnt == CW'(15)) ? ST_END : ST_CRC;
            state[I_END]:
                state_nx = ST_WSTAT;
            state[I_WSTAT]: begin
                if (!d0_in)
                    state_nx = ST_STAT;
                else if (cnt == CW'(STAT_TIMEOUT - 1))
                    state_nx = ST_DONE;
                else
                    state_nx = ST_WSTAT;
            end
            state[I_STAT]:
                state_nx = (cnt == CW'(2)) ? ST_BUSYW : ST_STAT;
            // cnt==0 is the token end bit, which is high and must not end busy
            state[I_BUSYW]:
                state_nx = (cnt != '0 && d0_in) ? ST_DONE : ST_BUSYW;
            state[I_DONE]:
                state_nx = ST_IDLE;
            default:
                state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        d0_oe  = state[I_PRE] | state[I_STRT] | state[I_DATA]
               | state[I_CRC] | state[I_END];
        d0_out = 1'b1;
        if (state[I_STRT]) d0_out = 1'b0;
        if (state[I_DATA]) d0_out = shift[63];
        if (state[I_CRC])  d0_out = crc[15];
        busy = !(state[I_IDLE] | state[I_DONE]);
        tfc  = state[I_DONE];
        rd_wrd_strb = !reset
                    && (accept
                        || (state[I_DATA] && cnt == CW'(60) && !last_word));
    end

    always_ff @(posedge sdc_clk) begin
        if (reset) begin
            cnt          <= '0;
            wcnt         <= '0;
            shift        <= '0;
            hold         <= '0;
            rd_q         <= 1'b0;
            crc          <= '0;
            crc_16       <= '0;
            tok          <= '0;
            crc_stat_err <= 1'b0;
        end else begin
            rd_q <= rd_wrd_strb;
            if (rd_q) hold <= dat_wrd;

            if (state_nx != state)
                cnt <= '0;
            else if (state[I_DATA] && last_bit)
                cnt <= '0;
            else if (state[I_IDLE])
                cnt <= '0;
            else if (state[I_BUSYW])
                cnt <= CW'(1);
            else
                cnt <= cnt + CW'(1);

            if (accept)
                wcnt <= '0;
            else if (state[I_DATA] && last_bit)
                wcnt <= wcnt + WW'(1);

            // word 0 may still be on dat_wrd when the preamble is one cycle
            if (state[I_PRE] && state_nx[I_STRT])
                shift <= rd_q ? dat_wrd : hold;
            else if (state[I_DATA])
                shift <= last_bit ? hold : {shift[62:0], 1'b0};

            if (accept) begin
                crc <= '0;
            end else if (state[I_DATA]) begin
                crc <= crc_step;
                if (state_nx[I_CRC]) crc_16 <= crc_step;
            end else if (state[I_CRC]) begin
                crc <= {crc[14:0], 1'b0};
            end

            if (state[I_STAT]) tok <= {tok[0], d0_in};

            if (accept)
                crc_stat_err <= 1'b0;
            else if (state[I_WSTAT] && state_nx[I_DONE])
                crc_stat_err <= 1'b1;
            else if (state[I_STAT] && state_nx[I_BUSYW]
                     && {tok, d0_in} != 3'b010)
                crc_stat_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdc_single_blk_wr_mod.sv
// Bench for sdc_single_blk_wr_mod: BRAM and card models, D0 frame and
// completion scoreboards fed by the stimulus, checked by a negedge monitor.
`timescale 1ns/1ps
module tb_sdc_single_blk_wr_mod;

    localparam int NWR_CYC = 2;
    localparam int WORDS   = 64;
    localparam int FRAME   = NWR_CYC + 1 + 64 * WORDS + 16 + 1;

    logic        sdc_clk;
    logic        reset;
    logic [15:0] command;
    logic        strt_strb;
    logic [63:0] dat_wrd;
    logic        d0_in;
    logic        rd_wrd_strb;
    logic        d0_out;
    logic        d0_oe;
    logic        busy;
    logic        crc_stat_err;
    logic        tfc;
    logic [15:0] crc_16;

    sdc_single_blk_wr_mod dut (
        .sdc_clk      (sdc_clk),
        .reset        (reset),
        .command      (command),
        .strt_strb    (strt_strb),
        .dat_wrd      (dat_wrd),
        .d0_in        (d0_in),
        .rd_wrd_strb  (rd_wrd_strb),
        .d0_out       (d0_out),
        .d0_oe        (d0_oe),
        .busy         (busy),
        .crc_stat_err (crc_stat_err),
        .tfc          (tfc),
        .crc_16       (crc_16)
    );

    typedef struct {
        logic        err;
        logic [15:0] crc;
        int          off;
    } tfc_exp_t;

    typedef struct {
        bit         timeout;
        logic [2:0] tok;
        int         gap;
        int         busy_len;
    } card_t;

    bit         exp_bits[$];
    int         exp_len[$];
    tfc_exp_t   tfc_q[$];
    card_t      card_q[$];
    logic [63:0] words [64];

    int tests, fails;
    int cyc, rd_idx, strb_cnt, tfc_seen, oe_fall;
    int flen, ferr;
    bit prev_oe, aborting;

    initial begin
        sdc_clk = 1'b0;
        forever #5 sdc_clk = ~sdc_clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    always @(posedge sdc_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] crc_upd(input logic [15:0] c,
                                            input bit b);
        logic fb;
        fb = c[15] ^ b;
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
        return c;
    endfunction

    // BRAM FIFO: word appears the cycle after the pop strobe
    always @(negedge sdc_clk) begin
        if (rd_wrd_strb) begin
            dat_wrd = (rd_idx < 64) ? words[rd_idx] : 64'h0;
            rd_idx++;
        end
    end

    // Card: status token, end bit and busy after the host releases D0
    initial begin
        card_t c;
        bit    p;
        d0_in = 1'b1;
        p = 1'b0;
        forever begin
            @(posedge sdc_clk); #1;
            if (p && !d0_oe && !aborting && card_q.size() > 0) begin
                c = card_q.pop_front();
                if (!c.timeout) begin
                    for (int i = 0; i < c.gap; i++) begin
                        d0_in = 1'b1;
                        @(posedge sdc_clk); #1;
                    end
                    d0_in = 1'b0;
                    @(posedge sdc_clk); #1;
                    for (int j = 2; j >= 0; j--) begin
                        d0_in = c.tok[j];
                        @(posedge sdc_clk); #1;
                    end
                    d0_in = 1'b1;
                    @(posedge sdc_clk); #1;
                    for (int i = 0; i < c.busy_len; i++) begin
                        d0_in = 1'b0;
                        @(posedge sdc_clk); #1;
                    end
                    d0_in = 1'b1;
                end
            end
            p = d0_oe;
        end
    end

    always @(negedge sdc_clk) begin
        tfc_exp_t e;
        int el;
        bit eb;
        if (rd_wrd_strb) strb_cnt++;
        if (d0_oe) begin
            if (!prev_oe) begin
                flen = 0;
                ferr = 0;
            end
            if (exp_bits.size() == 0) begin
                ferr++;
            end else begin
                eb = exp_bits.pop_front();
                if (d0_out !== eb) ferr++;
            end
            flen++;
        end else if (prev_oe) begin
            oe_fall = cyc;
            el = (exp_len.size() > 0) ? exp_len.pop_front() : -1;
            if (aborting) begin
                exp_bits.delete();
                strb_cnt = 0;
            end else begin
                chk("frame_len", flen, el);
                chk("frame_bit_errors", ferr, 0);
            end
        end
        if (tfc) begin
            tfc_seen++;
            if (tfc_q.size() == 0) begin
                chk("unexpected_tfc", 1, 0);
            end else begin
                e = tfc_q.pop_front();
                chk("tfc_crc_stat_err", crc_stat_err, e.err);
                chk("tfc_crc_16", crc_16, e.crc);
                chk("tfc_latency", cyc - oe_fall, e.off);
                chk("tfc_rd_strobes", strb_cnt, 64);
                chk("tfc_busy_low", busy, 0);
            end
            strb_cnt = 0;
        end
        prev_oe = d0_oe;
    end

    task automatic send_block(input int pat, input logic [15:0] cmd,
                              input bit timeout, input logic [2:0] tok,
                              input int gap, input int abort_at,
                              input bit extra_strt);
        logic [15:0] c;
        logic [63:0] w;
        logic [7:0]  b;
        tfc_exp_t    e;
        card_t       cd;
        int          t0;
        c = 16'h0;
        for (int i = 0; i < NWR_CYC; i++) exp_bits.push_back(1'b1);
        exp_bits.push_back(1'b0);
        for (int i = 0; i < WORDS; i++) begin
            b = i[7:0];
            w = (pat == 0) ? {8{b}} : 64'hFFFF_FFFF_FFFF_FFFF;
            words[i] = w;
            for (int k = 63; k >= 0; k--) begin
                exp_bits.push_back(w[k]);
                c = crc_upd(c, w[k]);
            end
        end
        if (pat != 0) c = 16'h7FA1;
        for (int k = 15; k >= 0; k--) exp_bits.push_back(c[k]);
        exp_bits.push_back(1'b1);
        exp_len.push_back(FRAME);
        if (abort_at == 0) begin
            e.err = timeout || (tok != 3'b010);
            e.crc = c;
            e.off = timeout ? 64 : gap + 26;
            tfc_q.push_back(e);
            cd.timeout  = timeout;
            cd.tok      = tok;
            cd.gap      = gap;
            cd.busy_len = 20;
            card_q.push_back(cd);
        end
        rd_idx = 0;
        t0 = tfc_seen;
        @(posedge sdc_clk); #1;
        command   = cmd;
        strt_strb = 1'b1;
        @(posedge sdc_clk); #1;
        strt_strb = 1'b0;
        @(negedge sdc_clk);
        chk("busy_after_accept", busy, 1);
        chk("err_clear_on_accept", crc_stat_err, 0);
        if (abort_at > 0) begin
            repeat (abort_at) @(posedge sdc_clk);
            #1;
            reset    = 1'b1;
            aborting = 1'b1;
            @(posedge sdc_clk);
            @(negedge sdc_clk);
            chk("abort_d0_oe", d0_oe, 0);
            chk("abort_busy", busy, 0);
            @(posedge sdc_clk); #1;
            reset = 1'b0;
            repeat (100) @(posedge sdc_clk);
            #1;
            aborting = 1'b0;
            chk("abort_no_tfc", tfc_seen, t0);
            return;
        end
        if (extra_strt) begin
            repeat (300) @(posedge sdc_clk);
            #1;
            strt_strb = 1'b1;
            @(posedge sdc_clk); #1;
            strt_strb = 1'b0;
        end
        for (int i = 0; i < 6000; i++) begin
            if (tfc_seen > t0) break;
            @(negedge sdc_clk);
        end
        if (tfc_seen == t0) chk("tfc_timeout", 0, 1);
        repeat (5) @(posedge sdc_clk);
    endtask

    initial begin
        int act;
        tests = 0; fails = 0; cyc = 0; rd_idx = 0; strb_cnt = 0;
        tfc_seen = 0; oe_fall = 0; flen = 0; ferr = 0;
        prev_oe = 1'b0; aborting = 1'b0;
        reset = 1'b1; command = 16'h0; strt_strb = 1'b0; dat_wrd = 64'h0;
        repeat (3) @(posedge sdc_clk);
        @(negedge sdc_clk);
        chk("rst_d0_out", d0_out, 1);
        chk("rst_d0_oe", d0_oe, 0);
        chk("rst_rd_wrd_strb", rd_wrd_strb, 0);
        chk("rst_busy", busy, 0);
        chk("rst_crc_stat_err", crc_stat_err, 0);
        chk("rst_tfc", tfc, 0);
        chk("rst_crc_16", crc_16, 0);
        @(posedge sdc_clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge sdc_clk);

        send_block(0, 16'h1800, 1'b0, 3'b010, 3, 0, 1'b0);
        send_block(1, 16'h1900, 1'b0, 3'b101, 5, 0, 1'b0);
        send_block(0, 16'h1800, 1'b0, 3'b010, 1, 0, 1'b1);
        send_block(0, 16'h1800, 1'b1, 3'b010, 0, 0, 1'b0);

        act = 0;
        @(posedge sdc_clk); #1;
        command   = 16'h1100;
        strt_strb = 1'b1;
        @(negedge sdc_clk);
        if (rd_wrd_strb) act++;
        @(posedge sdc_clk); #1;
        strt_strb = 1'b0;
        repeat (50) begin
            @(negedge sdc_clk);
            if (busy || d0_oe || rd_wrd_strb) act++;
        end
        chk("non_write_cmd_idle", act, 0);

        send_block(0, 16'h1800, 1'b0, 3'b010, 2, 1000, 1'b0);
        send_block(1, 16'h1800, 1'b0, 3'b010, 4, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
